// File: rtl/demux_tdm.sv
// Time-division demultiplexer: steers an upstream 4:1 mux via S, samples its serial
// output Y once per enabled cycle and rebuilds the parallel word D, one frame per N slots.
//
//   state      | meaning
//   SLOT0      | idle or frame start, nothing of the current frame captured (S == 0)
//   SLOTk      | slots 0..k-1 captured, sampling slot k on the next enabled edge
//   SLOT(N-1)  | last slot; the next enabled edge completes the frame and wraps
module demux_tdm #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             Y,
  output logic [SEL_W-1:0] S,
  output logic [N-1:0]     D,
  output logic             valid,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N - 1);

  logic [SEL_W-1:0] r_s;
  logic [N-1:0]     r_shadow;
  logic [N-1:0]     r_d;
  logic             r_valid;
  logic             r_busy;
  logic [7:0]       r_frame_cnt;

  logic [SEL_W-1:0] w_s_nxt;
  logic [N-1:0]     w_shadow_nxt;
  logic [N-1:0]     w_d_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic [7:0]       w_frame_cnt_nxt;
  logic             w_last;

  assign w_last = (r_s == LAST_SLOT);

  always_comb begin
    w_s_nxt         = r_s;
    w_shadow_nxt    = r_shadow;
    w_d_nxt         = r_d;
    w_valid_nxt     = 1'b0;
    w_busy_nxt      = r_busy;
    w_frame_cnt_nxt = r_frame_cnt;
    if (sync) begin
      w_s_nxt      = '0;
      w_shadow_nxt = '0;
      w_busy_nxt   = 1'b0;
    end else if (en) begin
      w_shadow_nxt[r_s] = Y;
      if (w_last) begin
        // completed word: current bit lands in the MSB, earlier slots below it
        w_d_nxt         = w_shadow_nxt;
        w_s_nxt         = '0;
        w_busy_nxt      = 1'b0;
        w_valid_nxt     = 1'b1;
        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
      end else begin
        w_s_nxt    = r_s + 1'b1;
        w_busy_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s         <= '0;
      r_shadow    <= '0;
      r_d         <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_s         <= w_s_nxt;
      r_shadow    <= w_shadow_nxt;
      r_d         <= w_d_nxt;
      r_valid     <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  assign S         = r_s;
  assign D         = r_d;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_demux_tdm.sv
// Bench for demux_tdm: directed steps from the test plan plus a random phase, all
// checked against a slot-level reference model of the frame reassembly rules.
module tb_demux_tdm;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sync;
  logic       Y;
  logic [1:0] S;
  logic [3:0] D;
  logic       valid;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int       m_slot;
  bit [3:0] m_frame;
  bit [3:0] m_d;
  bit       m_valid;
  int       m_cnt;
  bit [3:0] src;

  demux_tdm #(.N(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .Y         (Y),
    .S         (S),
    .D         (D),
    .valid     (valid),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, advance the model on the edge, check just after it
  task automatic step(input bit r, input bit s, input bit e, input bit y);
    rst  = r;
    sync = s;
    en   = e;
    Y    = y;
    @(posedge clk);
    if (r) begin
      m_slot = 0; m_frame = '0; m_d = '0; m_valid = 0; m_cnt = 0;
    end else if (s) begin
      m_slot = 0; m_frame = '0; m_valid = 0;
    end else if (e) begin
      m_frame[m_slot] = y;
      if (m_slot == 3) begin
        m_d = m_frame; m_slot = 0; m_valid = 1; m_cnt = (m_cnt + 1) % 256;
      end else begin
        m_slot++; m_valid = 0;
      end
    end else begin
      m_valid = 0;
    end
    #1;
    chk("S", 32'(S), 32'(m_slot));
    chk("D", 32'(D), 32'(m_d));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_slot != 0));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  // upstream mux: Y = src[slot] using the bench's own slot position
  task automatic mux_step(input bit e);
    step(1'b0, 1'b0, e, src[m_slot[1:0]]);
  endtask

  initial begin
    int nv;
    m_slot = 0; m_frame = '0; m_d = '0; m_valid = 0; m_cnt = 0;

    // 1: reset then continuous frames
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    src = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk("t1_S_seq", 32'(S), 32'(i));
      mux_step(1);
    end
    chk("t1_D", 32'(D), 32'h1);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);

    // 2: pattern change, D holds old word until completion
    src = 4'b1010;
    for (int i = 0; i < 3; i++) mux_step(1);
    chk("t2_D_hold", 32'(D), 32'h1);
    mux_step(1);
    chk("t2_D", 32'(D), 32'hA);
    chk("t2_cnt", 32'(frame_cnt), 32'd2);

    // 3: pause after slot 1
    mux_step(1);
    mux_step(1);
    for (int i = 0; i < 5; i++) begin
      mux_step(0);
      chk("t3_S_pause", 32'(S), 32'd2);
      chk("t3_busy_pause", 32'(busy), 32'd1);
    end
    mux_step(1);
    mux_step(1);
    chk("t3_D", 32'(D), 32'hA);

    // 4: realign at S=2 with Y=1
    src = 4'b0110;
    mux_step(1);
    mux_step(1);
    step(0, 1, 1, 1);
    chk("t4_S", 32'(S), 32'd0);
    chk("t4_D_hold", 32'(D), 32'hA);
    for (int i = 0; i < 4; i++) mux_step(1);
    chk("t4_D", 32'(D), 32'h6);

    // 5: reset mid-frame at S=3, with sync and en also high
    for (int i = 0; i < 3; i++) mux_step(1);
    chk("t5_S_pre", 32'(S), 32'd3);
    step(1, 1, 1, 1);
    chk("t5_D", 32'(D), 32'd0);
    mux_step(0);
    chk("t5_no_valid", 32'(valid), 32'd0);

    // 6: 256 frames of random words, counter wraps
    nv = 0;
    for (int f = 0; f < 256; f++) begin
      src = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        mux_step(1);
        if (valid) nv++;
      end
    end
    chk("t6_valid_pulses", 32'(nv), 32'd256);
    chk("t6_cnt_wrap", 32'(frame_cnt), 32'd0);

    // random phase: mixed en/sync/rst with arbitrary Y
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_tdm.md
Name: demux_tdm

Overview:
- Time-division demultiplexer: the receiving end of the 4:1 dataflow mux path.
- Drives the slot select `S` that steers an upstream `mux_fluxo`, samples that mux's single-bit output `Y` once per clock, and routes each bit to its channel.
- Rebuilds the 4-bit parallel word `D` and flags each completed frame.
- Sits between a serial mux link and parallel consumer logic.

Parameters:
- N, 4: number of channels/slots per frame; must be a power of 2, at least 2.
- SEL_W, 2: select width; must equal log2(N).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  slot advance enable; low pauses the frame with no capture.
- sync  input  1  frame realign; forces the next sample to slot 0.
- Y  input  1  serial bit from the upstream mux, valid for the current `S`.
- S  output  SEL_W  current slot select, driven to the upstream mux.
- D  output  N  last complete reconstructed word; bit k = channel k.
- valid  output  1  one-cycle pulse; `D` was updated on the previous edge.
- busy  output  1  high while a frame is partially captured (at least one slot taken, frame not yet complete).
- frame_cnt  output  8  completed-frame counter, wraps 255 -> 0.

Behaviour:
- Reset (rst high at an edge): S=0, D=0, valid=0, busy=0, frame_cnt=0, internal shadow register=0.
  - rst has priority over sync and en.
  - Reset mid-frame discards the partial frame; D keeps no partial bits.
- Datapath registers:
  - shadow[N-1:0] collects bits of the frame in progress.
  - D is updated only on frame completion.
- Per edge, when rst=0, sync=0, en=1:
  - shadow[S] <= Y.
  - If S != N-1: S <= S+1; busy <= 1; valid <= 0.
  - If S == N-1:
    - D <= {Y, shadow[N-2:0]}, i.e. current bit in the MSB and earlier slots below it.
    - S <= 0 (wrap); busy <= 0; valid <= 1; frame_cnt <= frame_cnt+1 (mod 256).
- Per edge, when rst=0, sync=0, en=0:
  - No capture; S, shadow, D, busy and frame_cnt hold; valid <= 0.
  - Pausing mid-frame is legal; the frame resumes where it stopped.
- Per edge, when rst=0, sync=1 (en don't-care):
  - S <= 0; shadow <= 0; busy <= 0; valid <= 0.
  - Y is not captured that cycle.
  - D and frame_cnt hold.
- Latency:
  - The bit at slot k is sampled on the edge where S==k.
  - D reflects a frame on the edge after its slot N-1 sample.
  - valid is high for exactly the clock cycle following that edge.
- Throughput: one frame per N enabled cycles; valid never asserts on two consecutive cycles when N ≥ 2.
- Timing: S is a pure register output, with no combinational path from Y to S.
- Derived state:
  - The FSM is implicit in S: states SLOT0..SLOT(N-1), advancing on en, with sync/rst returning to SLOT0.
  - busy == (S != 0).

Test Plan:
1. Reset then continuous frames: rst high for 2 cycles, checking S=0, D=0, valid=0, frame_cnt=0. Then en=1, with an upstream mux model holding D_src=4'b0001 and Y=D_src[S]. Required:
   - S sequence 0,1,2,3,0.
   - After the 4th edge, D=4'b0001, valid high for exactly 1 cycle, frame_cnt=1.
2. Pattern change: D_src=4'b1010 for the next frame. Required: D=4'b1010 and frame_cnt=2; D holds 4'b0001 until the completion edge.
3. Pause mid-frame: en=0 for 5 cycles after slot 1. Required:
   - S stays 2, busy stays 1, no valid pulse.
   - On resume, the frame completes with the correct word 4'b1010.
4. Realign: assert sync when S=2 with Y=1. Required:
   - S=0, busy=0, D unchanged.
   - The next 4 enabled cycles with D_src=4'b0110 yield D=4'b0110.
5. Reset mid-frame: rst at S=3. Required: all outputs return to reset values and no valid pulse. Simultaneous rst+sync+en: rst wins.
6. Counter wrap: run 256 frames. Required: frame_cnt returns to 0 with exactly 256 valid pulses counted.
